// File: rtl/pair_reduce_sequencer.sv
// Sequencer for the two-RAM pair-reduce datapath: loads RAM A through a
// valid/ready handshake, reduces word pairs into RAM B, then pulses Done.
module pair_reduce_sequencer #(
    parameter int DEPTH_A = 8,
    parameter int AW      = 3
) (
    input  logic          clock,
    input  logic          Reset,
    input  logic          Start,
    input  logic          InValid,
    output logic          InReady,
    output logic          WEA,
    output logic [AW-1:0] AddrA,
    output logic          LdX,
    output logic          LdY,
    output logic          WEB,
    output logic [AW-2:0] AddrB,
    output logic          Busy,
    output logic          Done
);

    localparam int BW = AW - 1;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] RDX  = 3'd2;
    localparam logic [2:0] RDY  = 3'd3;
    localparam logic [2:0] WRB  = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    localparam logic [AW-1:0] A_LAST = AW'(DEPTH_A - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DEPTH_A / 2 - 1);

    logic [2:0]    state;
    logic [2:0]    state_n;
    logic [AW-1:0] addr_a_n;
    logic [BW-1:0] addr_b_n;

    always_comb begin
        state_n  = state;
        addr_a_n = AddrA;
        addr_b_n = AddrB;
        unique case (state)
            IDLE: begin
                if (Start) state_n = LOAD;
            end
            LOAD: begin
                if (InValid) begin
                    if (AddrA == A_LAST) begin
                        addr_a_n = '0;
                        state_n  = RDX;
                    end else begin
                        addr_a_n = AddrA + 1'b1;
                    end
                end
            end
            RDX: begin
                addr_a_n = AddrA + 1'b1;
                state_n  = RDY;
            end
            // the increment after the last Y read wraps AddrA to 0
            RDY: begin
                addr_a_n = AddrA + 1'b1;
                state_n  = WRB;
            end
            WRB: begin
                if (AddrB == B_LAST) begin
                    state_n = DONE;
                end else begin
                    addr_b_n = AddrB + 1'b1;
                    state_n  = RDX;
                end
            end
            DONE: begin
                addr_a_n = '0;
                addr_b_n = '0;
                state_n  = IDLE;
            end
            default: begin
                addr_a_n = '0;
                addr_b_n = '0;
                state_n  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            state <= IDLE;
            AddrA <= '0;
            AddrB <= '0;
        end else begin
            state <= state_n;
            AddrA <= addr_a_n;
            AddrB <= addr_b_n;
        end
    end

    assign InReady = (state == LOAD);
    assign WEA     = InReady & InValid;
    assign LdX     = (state == RDX);
    assign LdY     = (state == RDY);
    assign WEB     = (state == WRB);
    assign Busy    = (state != IDLE);
    assign Done    = (state == DONE);

endmodule

// File: tb/tb_pair_reduce_sequencer.sv
// Scoreboard bench for pair_reduce_sequencer at DEPTH_A=8 and DEPTH_A=16.
// Expected strobe events are queued at Start and popped as the DUT emits them.
module tb_pair_reduce_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [1:0] start = 2'b00;
    logic [1:0] inv   = 2'b00;
    logic [1:0] rst   = 2'b11;

    logic       wea0, rdy0, ldx0, ldy0, web0, busy0, done0;
    logic [2:0] aa0;
    logic [1:0] ab0;
    logic       wea1, rdy1, ldx1, ldy1, web1, busy1, done1;
    logic [3:0] aa1;
    logic [2:0] ab1;

    pair_reduce_sequencer #(.DEPTH_A(8), .AW(3)) dut8 (
        .clock  (clock),
        .Reset  (rst[0]),
        .Start  (start[0]),
        .InValid(inv[0]),
        .InReady(rdy0),
        .WEA    (wea0),
        .AddrA  (aa0),
        .LdX    (ldx0),
        .LdY    (ldy0),
        .WEB    (web0),
        .AddrB  (ab0),
        .Busy   (busy0),
        .Done   (done0)
    );

    pair_reduce_sequencer #(.DEPTH_A(16), .AW(4)) dut16 (
        .clock  (clock),
        .Reset  (rst[1]),
        .Start  (start[1]),
        .InValid(inv[1]),
        .InReady(rdy1),
        .WEA    (wea1),
        .AddrA  (aa1),
        .LdX    (ldx1),
        .LdY    (ldy1),
        .WEB    (web1),
        .AddrB  (ab1),
        .Busy   (busy1),
        .Done   (done1)
    );

    typedef struct {
        int cyc;
        int kind;
        int addr;
    } ev_t;

    localparam int K_WEA  = 0;
    localparam int K_LDX  = 1;
    localparam int K_LDY  = 2;
    localparam int K_WEB  = 3;
    localparam int K_DONE = 4;

    ev_t q0[$];
    ev_t q1[$];

    int total  = 0;
    int passed = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // {wea, inready, ldx, ldy, web, busy, done}
    function automatic logic [6:0] sig(input int id);
        if (id == 0) return {wea0, rdy0, ldx0, ldy0, web0, busy0, done0};
        return {wea1, rdy1, ldx1, ldy1, web1, busy1, done1};
    endfunction

    function automatic int aa(input int id);
        return (id == 0) ? int'(aa0) : int'(aa1);
    endfunction

    function automatic int ab(input int id);
        return (id == 0) ? int'(ab0) : int'(ab1);
    endfunction

    function automatic int outs(input int id);
        return (int'(sig(id)) << 8) | (aa(id) << 4) | ab(id);
    endfunction

    function automatic int qsize(input int id);
        return (id == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void push(input int id, input int c,
                                 input int k, input int a);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.addr = a;
        if (id == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    function automatic ev_t pop(input int id);
        if (id == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // drop expectations for cycles after a reset is sampled
    function automatic void flush(input int id, input int lim);
        if (id == 0) begin
            while (q0.size() > 0 && q0[$].cyc > lim) void'(q0.pop_back());
        end else begin
            while (q1.size() > 0 && q1[$].cyc > lim) void'(q1.pop_back());
        end
    endfunction

    function automatic void expect_run(input int id, input int base,
                                       input int depth, input int stall);
        int n = base + 1;
        for (int i = 0; i < depth; i++) begin
            if (i == 4) n += stall;
            push(id, n, K_WEA, i);
            n++;
        end
        for (int p = 0; p < depth / 2; p++) begin
            push(id, n,     K_LDX, 2 * p);
            push(id, n + 1, K_LDY, 2 * p + 1);
            push(id, n + 2, K_WEB, p);
            n += 3;
        end
        push(id, n, K_DONE, 0);
    endfunction

    task automatic observe(input int id);
        logic [6:0] s;
        int n, kind, addr;
        ev_t e;
        s = sig(id);
        n = int'(s[6]) + int'(s[4]) + int'(s[3]) + int'(s[2]) + int'(s[0]);
        if (n == 0) return;
        chk("one_strobe", n, 1);
        chk("busy_active", int'(s[1]), 1);
        kind = s[6] ? K_WEA : s[4] ? K_LDX : s[3] ? K_LDY :
               s[2] ? K_WEB : K_DONE;
        addr = (kind == K_WEB) ? ab(id) : aa(id);
        if (qsize(id) == 0) begin
            chk("unexpected_event", kind, -1);
            return;
        end
        e = pop(id);
        chk("event_cycle", cyc, e.cyc);
        chk("event_kind", kind, e.kind);
        if (kind != K_DONE) chk("event_addr", addr, e.addr);
    endtask

    always @(negedge clock) begin
        observe(0);
        observe(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic go(input int id, input int stall, input int rst_at,
                      input bit pulses, input bit hold);
        int depth, len, base;
        bit fin;
        depth = (id == 0) ? 8 : 16;
        len   = depth + 3 * depth / 2 + 1;
        chk("busy_pre", int'(sig(id) & 7'b0000010), 0);
        start[id] = 1'b1;
        inv[id]   = 1'b1;
        base      = cyc;
        expect_run(id, base, depth, stall);
        if (hold) expect_run(id, base + len + 1, depth, 0);
        fin = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            tick();
            start[id] = hold ? (k <= len + 1) : (pulses && (k == 5 || k == 15));
            inv[id]   = !(k >= 5 && k < 5 + stall);
            rst[id]   = (k == rst_at);
            if (k == rst_at) flush(id, base + k);
            #2;
            if (k == 1) chk("busy_rise", int'(sig(id) >> 1) & 1, 1);
            if (k >= 5 && k < 5 + stall) begin
                chk("stall_ready", int'(sig(id) >> 5) & 1, 1);
                chk("stall_wea", int'(sig(id) >> 6) & 1, 0);
                chk("stall_addra", aa(id), 4);
            end
            if (k == rst_at && rst_at == 14) begin
                chk("wrb_web", int'(sig(id) >> 2) & 1, 1);
                chk("wrb_addrb", ab(id), 1);
            end
            if (rst_at > 0 && k == rst_at + 1) chk("reset_outs", outs(id), 0);
            if (qsize(id) == 0 && k > rst_at + 1) begin
                fin = 1'b1;
                break;
            end
        end
        chk("run_timeout", int'(fin), 1);
        chk("queue_drain", qsize(id), 0);
        chk("busy_fall", int'(sig(id) >> 1) & 1, 0);
        start[id] = 1'b0;
        inv[id]   = 1'b0;
        rst[id]   = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        #2;
        chk("reset_state8", outs(0), 0);
        chk("reset_state16", outs(1), 0);
        rst = 2'b00;
        tick();

        go(0, 0, 0, 1'b0, 1'b0);
        go(0, 3, 0, 1'b0, 1'b0);
        go(0, 0, 14, 1'b0, 1'b0);
        go(0, 0, 0, 1'b0, 1'b0);
        go(0, 0, 0, 1'b1, 1'b0);
        go(0, 0, 0, 1'b0, 1'b1);

        rst[0]   = 1'b1;
        start[0] = 1'b1;
        tick();
        rst[0]   = 1'b0;
        start[0] = 1'b0;
        #2;
        chk("rst_start_idle", outs(0), 0);
        tick();
        #2;
        chk("rst_start_after", outs(0), 0);

        go(0, 0, 3, 1'b0, 1'b0);
        go(1, 0, 0, 1'b0, 1'b0);

        tick();
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
